// File: rtl/state_sequencer_pkg.sv
// Shared constants and types for the state sequencer control path.
package state_sequencer_pkg;

  localparam int DEF_STATE_W    = 4;
  localparam int DEF_NUM_STATES = 9;
  localparam int DEF_WRAP       = 1;

  // What the sequencer does on the coming edge, after priority resolution.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_REJECT = 2'd2,
    ACT_STEP   = 2'd3
  } seq_action_e;

endpackage

// File: rtl/state_sequencer_onehot_decoder.sv
// Parametrised binary-to-one-hot decoder; purely combinational.
module onehot_decoder #(
  parameter int IN_W = 4
) (
  input  logic [IN_W-1:0]      code,
  output logic [2**IN_W-1:0]   onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/state_sequencer.sv
// Bounded state index sequencer with load, wrap/saturate and a registered one-hot selector.
module state_sequencer
  import state_sequencer_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int WRAP       = DEF_WRAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [STATE_W-1:0]    load_state,
  output logic [STATE_W-1:0]    current_state,
  output logic [2**STATE_W-1:0] selector,
  output logic                  last,
  output logic                  wrapped,
  output logic                  load_err
);

  localparam int                 SEL_W    = 2**STATE_W;
  localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(NUM_STATES - 1);
  // One extra bit so NUM_STATES == 2**STATE_W is representable.
  localparam logic [STATE_W:0]   NUM_EXT  = (STATE_W + 1)'(NUM_STATES);

  seq_action_e        action;
  logic [STATE_W-1:0] next_state;
  logic [SEL_W-1:0]   next_selector;
  logic               next_wrapped;
  logic               next_load_err;

  always_comb begin
    action = ACT_HOLD;
    if (load) begin
      action = ({1'b0, load_state} < NUM_EXT) ? ACT_LOAD : ACT_REJECT;
    end else if (en) begin
      action = ACT_STEP;
    end
  end

  always_comb begin
    next_state    = current_state;
    next_wrapped  = 1'b0;
    next_load_err = 1'b0;
    case (action)
      ACT_LOAD:   next_state    = load_state;
      ACT_REJECT: next_load_err = 1'b1;
      ACT_STEP: begin
        if (current_state != LAST_IDX) begin
          next_state = current_state + STATE_W'(1);
        end else if (WRAP != 0) begin
          next_state   = '0;
          next_wrapped = 1'b1;
        end
      end
      default: next_state = current_state;
    endcase
  end

  onehot_decoder #(
    .IN_W (STATE_W)
  ) u_decoder (
    .code   (next_state),
    .onehot (next_selector)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_state <= '0;
      selector      <= SEL_W'(1);
      last          <= 1'b0;
      wrapped       <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      current_state <= next_state;
      selector      <= next_selector;
      last          <= (next_state == LAST_IDX);
      wrapped       <= next_wrapped;
      load_err      <= next_load_err;
    end
  end

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: three configurations driven together, checked against an integer model.
module tb_state_sequencer;

  // Instance 0: defaults (wrap, 9 states); 1: saturating; 2: STATE_W=3, 8 states.
  localparam int N_P[3]  = '{9, 9, 8};
  localparam int W_P[3]  = '{1, 0, 1};
  localparam int SW_P[3] = '{4, 4, 3};

  typedef struct {
    int state;
    bit wrapped;
    bit err;
  } model_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_state = '0;

  logic [3:0]  cs_a, cs_b;
  logic [2:0]  cs_c;
  logic [15:0] sel_a, sel_b;
  logic [7:0]  sel_c;
  logic        last_a, last_b, last_c;
  logic        wr_a, wr_b, wr_c;
  logic        le_a, le_b, le_c;

  model_t m[3];
  bit     checking = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;

  state_sequencer dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_state(load_state),
    .current_state(cs_a), .selector(sel_a), .last(last_a), .wrapped(wr_a), .load_err(le_a)
  );

  state_sequencer #(.STATE_W(4), .NUM_STATES(9), .WRAP(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_state(load_state),
    .current_state(cs_b), .selector(sel_b), .last(last_b), .wrapped(wr_b), .load_err(le_b)
  );

  state_sequencer #(.STATE_W(3), .NUM_STATES(8), .WRAP(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_state(load_state[2:0]),
    .current_state(cs_c), .selector(sel_c), .last(last_c), .wrapped(wr_c), .load_err(le_c)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic model_t next_model(input model_t cur, input int i,
                                        input logic e, input logic l, input logic [3:0] ls_in);
    model_t nx;
    int ls;
    ls = int'(ls_in) % (1 << SW_P[i]);
    nx.state   = cur.state;
    nx.wrapped = 1'b0;
    nx.err     = 1'b0;
    if (l) begin
      if (ls < N_P[i]) nx.state = ls;
      else             nx.err   = 1'b1;
    end else if (e) begin
      if (cur.state < N_P[i] - 1) begin
        nx.state = cur.state + 1;
      end else if (W_P[i] == 1) begin
        nx.state   = 0;
        nx.wrapped = 1'b1;
      end
    end
    return nx;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) m[i] <= '{state: 0, wrapped: 1'b0, err: 1'b0};
      else     m[i] <= next_model(m[i], i, en, load, load_state);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_inst(input int i, input int cs, input int sel,
                            input bit lst, input bit wr, input bit le);
    cmp($sformatf("state[%0d]", i), cs, m[i].state);
    cmp($sformatf("selector[%0d]", i), sel, 1 << m[i].state);
    cmp($sformatf("onehot[%0d]", i), $countones(sel), 1);
    cmp($sformatf("last[%0d]", i), int'(lst), int'(m[i].state == N_P[i] - 1));
    cmp($sformatf("wrapped[%0d]", i), int'(wr), int'(m[i].wrapped));
    cmp($sformatf("load_err[%0d]", i), int'(le), int'(m[i].err));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_inst(0, int'(cs_a), int'(sel_a), last_a, wr_a, le_a);
      check_inst(1, int'(cs_b), int'(sel_b), last_b, wr_b, le_b);
      check_inst(2, int'(cs_c), int'(sel_c), last_c, wr_c, le_c);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic e, input logic l, input logic [3:0] ls);
    en = e;
    load = l;
    load_state = ls;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_cs_a"}, int'(cs_a), 0);
    cmp({tag, "_sel_a"}, int'(sel_a), 16'h0001);
    cmp({tag, "_last_a"}, int'(last_a), 0);
    cmp({tag, "_wr_a"}, int'(wr_a), 0);
    cmp({tag, "_le_a"}, int'(le_a), 0);
    cmp({tag, "_cs_b"}, int'(cs_b), 0);
    cmp({tag, "_sel_c"}, int'(sel_c), 8'h01);
  endtask

  // Assert reset between edges, then release it while en/load are active.
  task automatic mid_cycle_reset(input string tag);
    #1 rst = 1'b1;
    #1 check_reset_values(tag);
    en = 1'b1;
    load = 1'b1;
    load_state = 4'd3;
    @(posedge clk);
    #2;
    check_reset_values({tag, "_held"});
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("por");
    rst = 1'b0;
    checking = 1'b1;

    // Free-running sweep across the wrap point of every configuration.
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 1'b0, 4'd0);
      cmp($sformatf("sweep_cs_a_%0d", k), int'(cs_a), k % 9);
      cmp($sformatf("sweep_wr_a_%0d", k), int'(wr_a), int'(k == 9));
      cmp($sformatf("sweep_last_a_%0d", k), int'(last_a), int'(k % 9 == 8));
      cmp($sformatf("sweep_cs_b_%0d", k), int'(cs_b), (k < 8) ? k : 8);
      cmp($sformatf("sweep_wr_b_%0d", k), int'(wr_b), 0);
      cmp($sformatf("sweep_sel_c_%0d", k), int'(sel_c), 1 << (k % 8));
      cmp($sformatf("sweep_wr_c_%0d", k), int'(wr_c), int'(k == 8));
    end
    cmp("sat_sel_b", int'(sel_b), 16'h0100);

    // Load in range beats en; out-of-range load is rejected.
    drive(1'b1, 1'b1, 4'd6);
    cmp("load6_cs_a", int'(cs_a), 6);
    cmp("load6_sel_a", int'(sel_a), 16'h0040);
    drive(1'b1, 1'b1, 4'd12);
    cmp("load12_cs_a", int'(cs_a), 6);
    cmp("load12_le_a", int'(le_a), 1);
    cmp("load12_le_b", int'(le_b), 1);
    cmp("load12_cs_c", int'(cs_c), 4);
    cmp("load12_le_c", int'(le_c), 0);
    drive(1'b0, 1'b0, 4'd0);
    cmp("le_clear_a", int'(le_a), 0);

    // Hold with en low.
    drive(1'b0, 1'b1, 4'd5);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 4'd0);
      cmp("hold_cs_a", int'(cs_a), 5);
      cmp("hold_sel_a", int'(sel_a), 16'h0020);
      cmp("hold_pulses_a", int'({wr_a, le_a}), 0);
    end

    // Load 0 from the last state does not count as a wrap.
    drive(1'b0, 1'b1, 4'd8);
    cmp("at8_last_a", int'(last_a), 1);
    drive(1'b1, 1'b1, 4'd0);
    cmp("load0_cs_a", int'(cs_a), 0);
    cmp("load0_wr_a", int'(wr_a), 0);

    // Reset at state 7 with a load_err pulse outstanding.
    drive(1'b0, 1'b1, 4'd7);
    drive(1'b1, 1'b1, 4'd13);
    cmp("pre_rst_le_a", int'(le_a), 1);
    mid_cycle_reset("rst7");
    drive(1'b1, 1'b0, 4'd0);
    cmp("post_rst_cs_a", int'(cs_a), 1);

    // Reset with a wrapped pulse outstanding.
    drive(1'b0, 1'b1, 4'd8);
    drive(1'b1, 1'b0, 4'd0);
    cmp("pre_rst_wr_a", int'(wr_a), 1);
    mid_cycle_reset("rstwr");
    drive(1'b1, 1'b0, 4'd0);
    cmp("post_rstwr_cs_a", int'(cs_a), 1);

    // Randomized traffic, model-checked every cycle.
    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            4'($urandom_range(0, 15)));
      if ($urandom_range(0, 80) == 0) begin
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
    end

    drive(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
